// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes symbolic instruction requests into 32-bit MIPS
// words and streams them into imem, holding the CPU until the program is loaded.
//
// state | meaning
// IDLE  | ready for the next request
// ENC   | encode the latched request into imem_wd (or flag it as illegal)
// WR    | one-cycle imem write at imem_addr, then advance the address and count
// DONE  | program loaded (or imem full); CPU released until reset
module instr_encoder_loader #(
    parameter int IMEM_DEPTH = 64,
    parameter int ADDR_W     = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_kind,
    input  logic [4:0]        req_rs,
    input  logic [4:0]        req_rt,
    input  logic [4:0]        req_rd,
    input  logic [15:0]       req_imm,
    input  logic [25:0]       req_target,
    input  logic              req_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wd,
    output logic              cpu_hold,
    output logic [ADDR_W:0]   word_count,
    output logic              err_illegal,
    output logic              err_full
);

    typedef enum logic [1:0] {S_IDLE, S_ENC, S_WR, S_DONE} state_t;

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(IMEM_DEPTH);

    state_t        state, state_nxt;
    logic [3:0]    kind_q;
    logic [4:0]    rs_q, rt_q, rd_q;
    logic [15:0]   imm_q;
    logic [25:0]   tgt_q;
    logic          last_q;
    logic [31:0]   enc_word;
    logic          enc_legal;
    logic [ADDR_W:0] cnt_inc;
    logic          full_hit;

    assign cnt_inc  = word_count + 1'b1;
    assign full_hit = (cnt_inc == DEPTH_CNT);

    // Encode the latched request; only the fields of the selected format reach the word.
    always_comb begin
        enc_word  = 32'h0000_0000;
        enc_legal = 1'b1;
        case (kind_q)
            4'd0:    enc_word = {6'h00, rs_q, rt_q, rd_q, 5'd0, 6'h20};
            4'd1:    enc_word = {6'h00, rs_q, rt_q, rd_q, 5'd0, 6'h22};
            4'd2:    enc_word = {6'h00, rs_q, rt_q, rd_q, 5'd0, 6'h24};
            4'd3:    enc_word = {6'h00, rs_q, rt_q, rd_q, 5'd0, 6'h25};
            4'd4:    enc_word = {6'h00, rs_q, rt_q, rd_q, 5'd0, 6'h2A};
            4'd5:    enc_word = {6'h23, rs_q, rt_q, imm_q};
            4'd6:    enc_word = {6'h2B, rs_q, rt_q, imm_q};
            4'd7:    enc_word = {6'h04, rs_q, rt_q, imm_q};
            4'd8:    enc_word = {6'h05, rs_q, rt_q, imm_q};
            4'd9:    enc_word = {6'h08, rs_q, rt_q, imm_q};
            4'd10:   enc_word = {6'h02, tgt_q};
            4'd11:   enc_word = 32'h0000_0000;
            default: enc_legal = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode and state-derived handshake/strobe outputs.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        imem_we   = 1'b0;
        cpu_hold  = 1'b1;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = S_ENC;
            end
            S_ENC: begin
                if (enc_legal)   state_nxt = S_WR;
                else if (last_q) state_nxt = S_DONE;
                else             state_nxt = S_IDLE;
            end
            S_WR: begin
                imem_we = 1'b1;
                if (last_q || full_hit) state_nxt = S_DONE;
                else                    state_nxt = S_IDLE;
            end
            S_DONE: cpu_hold = 1'b0;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Capture the request fields on accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            kind_q <= 4'd0;
            rs_q   <= 5'd0;
            rt_q   <= 5'd0;
            rd_q   <= 5'd0;
            imm_q  <= 16'd0;
            tgt_q  <= 26'd0;
            last_q <= 1'b0;
        end else if (state == S_IDLE && req_valid) begin
            kind_q <= req_kind;
            rs_q   <= req_rs;
            rt_q   <= req_rt;
            rd_q   <= req_rd;
            imm_q  <= req_imm;
            tgt_q  <= req_target;
            last_q <= req_last;
        end
    end

    // Write datapath: word register, address/count advance and sticky errors.
    // The address stops at the last word when imem fills instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            imem_wd     <= 32'h0000_0000;
            imem_addr   <= '0;
            word_count  <= '0;
            err_illegal <= 1'b0;
            err_full    <= 1'b0;
        end else begin
            if (state == S_ENC) begin
                if (enc_legal) imem_wd <= enc_word;
                else           err_illegal <= 1'b1;
            end
            if (state == S_WR) begin
                word_count <= cnt_inc;
                if (full_hit) begin
                    if (!last_q) err_full <= 1'b1;
                end else begin
                    imem_addr <= imem_addr + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: a timestamp-based reference model checks every
// output on every cycle; directed scenarios also pin hand-computed words.
module tb_instr_encoder_loader;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [3:0]    req_kind = 4'd0;
    logic [4:0]    req_rs = 5'd0, req_rt = 5'd0, req_rd = 5'd0;
    logic [15:0]   req_imm = 16'd0;
    logic [25:0]   req_target = 26'd0;
    logic          req_last = 1'b0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wd;
    logic          cpu_hold;
    logic [AW:0]   word_count;
    logic          err_illegal, err_full;

    instr_encoder_loader #(.IMEM_DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_kind(req_kind), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
        .req_imm(req_imm), .req_target(req_target), .req_last(req_last),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wd(imem_wd),
        .cpu_hold(cpu_hold), .word_count(word_count),
        .err_illegal(err_illegal), .err_full(err_full)
    );

    always #5 clk = ~clk;

    int tot_m = 0, bad_m = 0, tot_d = 0, bad_d = 0;
    int cyc = 0;
    int nw  = 0;
    logic [31:0] wlog_wd [256];
    int          wlog_addr [256];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Reference encoding from the instruction-format rules, as plain arithmetic.
    function automatic logic [31:0] ref_word(input int kind, input longint rs, input longint rt,
                                             input longint rd, input longint imm, input longint tgt);
        int funct [5] = '{32, 34, 36, 37, 42};
        int op    [5] = '{35, 43, 4, 5, 8};
        longint v;
        if (kind <= 4)       v = rs * 2097152 + rt * 65536 + rd * 2048 + funct[kind];
        else if (kind <= 9)  v = longint'(op[kind-5]) * 67108864 + rs * 2097152 + rt * 65536 + imm;
        else if (kind == 10) v = 2 * 67108864 + tgt;
        else                 v = 0;
        return v[31:0];
    endfunction

    // Model + per-cycle compare. A job is timestamped by the cycle it was accepted:
    // encode cycle = acc, write cycle = acc+1, count/address advance visible at acc+2.
    initial begin
        bit m_we, m_ready, m_hold, m_ill, m_full, m_done;
        int m_addr, m_count;
        logic [31:0] m_wd;
        bit job_act, job_legal, job_last;
        int job_acc;
        logic [31:0] job_word;
        bit rst_prev, armed;
        logic [63:0] act [8];
        logic [63:0] exq [8];
        string nm [8] = '{"imem_we", "imem_addr", "imem_wd", "word_count",
                          "cpu_hold", "req_ready", "err_illegal", "err_full"};
        m_we = 0; m_ready = 0; m_hold = 1; m_ill = 0; m_full = 0; m_done = 0;
        m_addr = 0; m_count = 0; m_wd = 0; job_act = 0; job_legal = 0; job_last = 0;
        job_acc = 0; job_word = 0; rst_prev = 0; armed = 0;
        forever begin
            @(negedge clk);
            if (rst_prev) begin
                m_we = 0; m_ill = 0; m_full = 0; m_done = 0;
                m_addr = 0; m_count = 0; m_wd = 0; job_act = 0; armed = 1;
            end else if (armed && job_act) begin
                if (cyc == job_acc + 1) begin
                    if (job_legal) begin
                        m_wd = job_word;
                        m_we = 1;
                    end else begin
                        m_ill = 1;
                        if (job_last) m_done = 1;
                        job_act = 0;
                    end
                end else if (cyc == job_acc + 2) begin
                    m_we = 0;
                    m_count++;
                    if (m_count == DEPTH) begin
                        m_done = 1;
                        if (!job_last) m_full = 1;
                    end else begin
                        m_addr++;
                        if (job_last) m_done = 1;
                    end
                    job_act = 0;
                end
            end
            m_ready = armed && !job_act && !m_done;
            m_hold  = !m_done;
            if (armed) begin
                if (imem_we === 1'b1 && nw < 256) begin
                    wlog_wd[nw]   = imem_wd;
                    wlog_addr[nw] = int'(imem_addr);
                    nw++;
                end
                act = '{64'(imem_we), 64'(imem_addr), 64'(imem_wd), 64'(word_count),
                        64'(cpu_hold), 64'(req_ready), 64'(err_illegal), 64'(err_full)};
                exq = '{64'(m_we), 64'(m_addr), 64'(m_wd), 64'(m_count),
                        64'(m_hold), 64'(m_ready), 64'(m_ill), 64'(m_full)};
                for (int i = 0; i < 8; i++) begin
                    tot_m++;
                    if (act[i] !== exq[i]) begin
                        bad_m++;
                        $display("FAIL %s got=%0h want=%0h cyc=%0d", nm[i], act[i], exq[i], cyc);
                    end
                end
            end
            rst_prev = reset;
            if (armed && !reset && m_ready && req_valid === 1'b1) begin
                job_act   = 1;
                job_acc   = cyc + 1;
                job_legal = (req_kind <= 4'd11);
                job_last  = req_last;
                job_word  = ref_word(int'(req_kind), longint'(req_rs), longint'(req_rt),
                                     longint'(req_rd), longint'(req_imm), longint'(req_target));
            end
        end
    end

    task automatic dchk(input string name, input logic [63:0] got, input logic [63:0] want);
        tot_d++;
        if (got !== want) begin
            bad_d++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic scramble();
        req_kind   = 4'($urandom);
        req_rs     = 5'($urandom);
        req_rt     = 5'($urandom);
        req_rd     = 5'($urandom);
        req_imm    = 16'($urandom);
        req_target = 26'($urandom);
        req_last   = 1'($urandom);
    endtask

    task automatic do_reset();
        req_valid = 1'b0;
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        tick();
    endtask

    // Present one request and return #1 after the edge that accepted it.
    task automatic send(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt,
                        input logic last);
        bit done_ok;
        done_ok = 0;
        req_kind = k; req_rs = rs; req_rt = rt; req_rd = rd;
        req_imm = imm; req_target = tgt; req_last = last;
        req_valid = 1'b1;
        for (int i = 0; i < 40 && !done_ok; i++) begin
            @(negedge clk);
            if (req_ready === 1'b1) begin
                tick();
                done_ok = 1;
            end
        end
        req_valid = 1'b0;
        scramble();
        if (!done_ok) begin
            tot_d++;
            bad_d++;
            $display("FAIL send_timeout got=not_accepted want=accepted");
        end
    endtask

    int base;

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        // Pin the reference encoder against hand-computed words.
        dchk("ref_add",  64'(ref_word(0, 1, 2, 3, 'hFFFF, 'h3FF_FFFF)), 64'h0022_1820);
        dchk("ref_lw",   64'(ref_word(5, 0, 2, 31, 'h0050, 'h3FF_FFFF)), 64'h8C02_0050);
        dchk("ref_bne",  64'(ref_word(8, 1, 2, 0, 'hFFFE, 0)), 64'h1422_FFFE);
        dchk("ref_j",    64'(ref_word(10, 31, 31, 31, 'hFFFF, 'h11)), 64'h0800_0011);
        dchk("ref_nop",  64'(ref_word(11, 31, 31, 31, 'hFFFF, 'h3FF_FFFF)), 64'h0);
        dchk("ref_sw",   64'(ref_word(6, 3, 4, 0, 'h0008, 0)), 64'hAC64_0008);

        // Reset state.
        do_reset();
        dchk("rst_count", 64'(word_count), 64'd0);
        dchk("rst_hold",  64'(cpu_hold), 64'd1);
        dchk("rst_ready", 64'(req_ready), 64'd1);
        dchk("rst_we",    64'(imem_we), 64'd0);

        // ADD, unused imm/target noisy.
        base = nw;
        send(4'd0, 5'd1, 5'd2, 5'd3, 16'hBEEF, 26'h2AB_CDEF, 1'b0);
        idle(4);
        dchk("t1_nwrites", 64'(nw - base), 64'd1);
        dchk("t1_wd",      64'(wlog_wd[base]), 64'h0022_1820);
        dchk("t1_addr",    64'(wlog_addr[base]), 64'd0);
        dchk("t1_count",   64'(word_count), 64'd1);

        // LW then BNE last.
        do_reset();
        base = nw;
        send(4'd5, 5'd0, 5'd2, 5'd17, 16'h0050, 26'h155_5555, 1'b0);
        send(4'd8, 5'd1, 5'd2, 5'd9, 16'hFFFE, 26'h0AA_AAAA, 1'b1);
        idle(4);
        req_valid = 1'b1;
        idle(5);
        req_valid = 1'b0;
        dchk("t2_nwrites", 64'(nw - base), 64'd2);
        dchk("t2_wd0",     64'(wlog_wd[base]), 64'h8C02_0050);
        dchk("t2_wd1",     64'(wlog_wd[base+1]), 64'h1422_FFFE);
        dchk("t2_addr1",   64'(wlog_addr[base+1]), 64'd1);
        dchk("t2_hold",    64'(cpu_hold), 64'd0);
        dchk("t2_ready",   64'(req_ready), 64'd0);

        // J, illegal kind 13, then ADD lands at addr 1.
        do_reset();
        base = nw;
        send(4'd10, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h000_0011, 1'b0);
        send(4'd13, 5'd1, 5'd1, 5'd1, 16'h1234, 26'h123_4567, 1'b0);
        send(4'd0, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 1'b0);
        idle(4);
        dchk("t3_nwrites", 64'(nw - base), 64'd2);
        dchk("t3_wd0",     64'(wlog_wd[base]), 64'h0800_0011);
        dchk("t3_illegal", 64'(err_illegal), 64'd1);
        dchk("t3_addr1",   64'(wlog_addr[base+1]), 64'd1);
        dchk("t3_wd1",     64'(wlog_wd[base+1]), 64'h0085_3020);

        // Continuous valid, no last: fill imem.
        do_reset();
        base = nw;
        for (int i = 0; i < 24; i++) begin
            scramble();
            req_kind  = 4'($urandom_range(0, 11));
            req_last  = 1'b0;
            req_valid = 1'b1;
            tick();
        end
        req_valid = 1'b0;
        idle(2);
        dchk("t4_nwrites", 64'(nw - base), 64'd4);
        for (int i = 0; i < 4; i++) dchk("t4_addr", 64'(wlog_addr[base+i]), 64'(i));
        dchk("t4_full",    64'(err_full), 64'd1);
        dchk("t4_addr_hold", 64'(imem_addr), 64'd3);
        dchk("t4_count",   64'(word_count), 64'd4);
        dchk("t4_hold",    64'(cpu_hold), 64'd0);

        // Reset during the write of the second word.
        do_reset();
        send(4'd1, 5'd3, 5'd3, 5'd3, 16'h0, 26'h0, 1'b0);
        send(4'd2, 5'd4, 5'd4, 5'd4, 16'h0, 26'h0, 1'b0);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        dchk("t5_we",    64'(imem_we), 64'd0);
        dchk("t5_count", 64'(word_count), 64'd0);
        dchk("t5_addr",  64'(imem_addr), 64'd0);
        dchk("t5_hold",  64'(cpu_hold), 64'd1);
        base = nw;
        send(4'd1, 5'd7, 5'd8, 5'd9, 16'hFFFF, 26'h0, 1'b0);
        idle(4);
        dchk("t5_reload_addr", 64'(wlog_addr[base]), 64'd0);
        dchk("t5_reload_wd",   64'(wlog_wd[base]), 64'h00E8_4822);

        // valid toggling while busy.
        do_reset();
        send(4'd3, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0, 1'b0);
        req_valid = 1'b1;
        dchk("t6_ready_enc", 64'(req_ready), 64'd0);
        tick();
        dchk("t6_ready_wr", 64'(req_ready), 64'd0);
        req_valid = 1'b0;
        tick();
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        idle(4);
        dchk("t6_count", 64'(word_count), 64'd2);

        // Randomized programs, occasional mid-program reset.
        for (int p = 0; p < 40; p++) begin
            int n;
            do_reset();
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                logic [3:0] k;
                if (cpu_hold === 1'b0) break;
                k = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(12, 15))
                                                : 4'($urandom_range(0, 11));
                send(k, 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom),
                     26'($urandom), (i == n - 1) ? 1'($urandom) : 1'b0);
                if ($urandom_range(0, 9) == 0) begin
                    idle($urandom_range(0, 2));
                    reset = 1'b1;
                    tick();
                    reset = 1'b0;
                end
                idle(3 + $urandom_range(0, 2));
            end
        end

        idle(2);
        $display("test done: total=%0d bad=%0d", tot_m + tot_d, bad_m + bad_d);
        $finish;
    end

endmodule
